periph_counter: RTL and testbench

Memory-mapped timer/counter peripheral on the peripheral branch of the data bus, directly downstream of the bus interface unit. It receives the address, write data and byte enables that the BIU forwards to the peripheral. It returns its count on the read-data lane, which the BIU selects for loads from 0x40004. It adds a prescaler, a compare match with optional auto-reload, and a level interrupt.

---
 rtl/periph_counter.sv | 129 ++++++++++++
 tb/tb_periph_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_counter.sv
// Memory-mapped timer/counter: prescaled up-counter with compare match,
// optional auto-reload and a level interrupt gated by IRQ_EN.
module periph_counter #(
  parameter logic [31:0] CTRL_ADDR  = 32'h0004_0000,
  parameter logic [31:0] COUNT_ADDR = 32'h0004_0004,
  parameter logic [31:0] CMP_ADDR   = 32'h0004_0008
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [3:0]  dwe_i,
  output logic [31:0] drdata_o,
  output logic        irq_o
);

  logic        en_q, en_d;
  logic        autoreload_q, autoreload_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic        pending_q, pending_d;

  logic        sel_ctrl, sel_count, sel_cmp;
  logic        clr_strobe, ack_strobe, count_wr;
  logic        tick, match;
  logic [31:0] count_load;

  assign sel_ctrl  = (daddr_i == CTRL_ADDR);
  assign sel_count = (daddr_i == COUNT_ADDR);
  assign sel_cmp   = (daddr_i == CMP_ADDR);

  // CLR and ACK live in CTRL byte 0 and act only for the cycle they are written.
  assign clr_strobe = sel_ctrl & dwe_i[0] & dwdata_i[1];
  assign ack_strobe = sel_ctrl & dwe_i[0] & dwdata_i[4];
  assign count_wr   = sel_count & (|dwe_i);

  assign tick  = en_q && (pre_cnt_q == prescale_q);
  assign match = tick && (count_q == cmp_q);

  always_comb begin
    en_d         = en_q;
    autoreload_d = autoreload_q;
    irq_en_d     = irq_en_q;
    prescale_d   = prescale_q;
    if (sel_ctrl && dwe_i[0]) begin
      en_d         = dwdata_i[0];
      autoreload_d = dwdata_i[2];
      irq_en_d     = dwdata_i[3];
    end
    if (sel_ctrl && dwe_i[1]) begin
      prescale_d = dwdata_i[15:8];
    end
  end

  always_comb begin
    cmp_d      = cmp_q;
    count_load = count_q;
    for (int i = 0; i < 4; i++) begin
      if (sel_cmp && dwe_i[i]) begin
        cmp_d[8*i +: 8] = dwdata_i[8*i +: 8];
      end
      if (dwe_i[i]) begin
        count_load[8*i +: 8] = dwdata_i[8*i +: 8];
      end
    end
  end

  // Software actions take priority over the running count.
  always_comb begin
    count_d = count_q;
    if (clr_strobe) begin
      count_d = 32'h0;
    end else if (count_wr) begin
      count_d = count_load;
    end else if (match && autoreload_q) begin
      count_d = 32'h0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr_strobe || tick) begin
      pre_cnt_d = 8'h0;
    end else if (en_q) begin
      pre_cnt_d = pre_cnt_q + 8'd1;
    end
  end

  // A match on the same edge as an ACK keeps the request pending.
  always_comb begin
    pending_d = pending_q;
    if (match) begin
      pending_d = 1'b1;
    end else if (ack_strobe) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      prescale_q   <= 8'h0;
      cmp_q        <= 32'hFFFF_FFFF;
      count_q      <= 32'h0;
      pre_cnt_q    <= 8'h0;
      pending_q    <= 1'b0;
    end else begin
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      irq_en_q     <= irq_en_d;
      prescale_q   <= prescale_d;
      cmp_q        <= cmp_d;
      count_q      <= count_d;
      pre_cnt_q    <= pre_cnt_d;
      pending_q    <= pending_d;
    end
  end

  assign drdata_o = sel_count ? count_q : 32'h0;
  assign irq_o    = pending_q & irq_en_q;

endmodule

// File: tb/tb_periph_counter.sv
// Self-checking bench for periph_counter: directed scenarios plus a random
// run, all compared against a cycle-level reference model of the register rules.
module tb_periph_counter;

  localparam logic [31:0] A_CTRL  = 32'h0004_0000;
  localparam logic [31:0] A_COUNT = 32'h0004_0004;
  localparam logic [31:0] A_CMP   = 32'h0004_0008;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] daddr_i = 32'h0;
  logic [31:0] dwdata_i = 32'h0;
  logic [3:0]  dwe_i = 4'h0;
  logic [31:0] drdata_o;
  logic        irq_o;

  int n_err = 0;
  int n_chk = 0;

  // reference model state
  bit        m_en, m_ar, m_ie, m_pending;
  bit [7:0]  m_ps, m_pre;
  bit [31:0] m_cmp, m_count;

  periph_counter dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .daddr_i (daddr_i),
    .dwdata_i(dwdata_i),
    .dwe_i   (dwe_i),
    .drdata_o(drdata_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_edge(input bit r, input bit [31:0] a, input bit [31:0] d, input bit [3:0] w);
    bit tick, match, clr, ack;
    bit [31:0] nxt;
    if (r) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0; m_pre = 0;
      m_cmp = 32'hFFFF_FFFF; m_count = 0; m_pending = 0;
      return;
    end
    tick  = m_en && (m_pre == m_ps);
    match = tick && (m_count == m_cmp);
    clr   = (a == A_CTRL) && w[0] && d[1];
    ack   = (a == A_CTRL) && w[0] && d[4];
    nxt = m_count;
    if (clr) nxt = 0;
    else if (a == A_COUNT && w != 0) begin
      for (int i = 0; i < 4; i++) if (w[i]) nxt[8*i +: 8] = d[8*i +: 8];
    end
    else if (match && m_ar) nxt = 0;
    else if (tick) nxt = m_count + 32'd1;
    if (clr || tick) m_pre = 0;
    else if (m_en) m_pre = m_pre + 8'd1;
    if (match) m_pending = 1;
    else if (ack) m_pending = 0;
    if (a == A_CTRL && w[0]) begin m_en = d[0]; m_ar = d[2]; m_ie = d[3]; end
    if (a == A_CTRL && w[1]) m_ps = d[15:8];
    if (a == A_CMP)
      for (int i = 0; i < 4; i++) if (w[i]) m_cmp[8*i +: 8] = d[8*i +: 8];
    m_count = nxt;
  endtask

  // one clock with the given bus cycle, then park on a COUNT read
  task automatic step(input bit r, input bit [31:0] a, input bit [31:0] d, input bit [3:0] w);
    reset_i = r; daddr_i = a; dwdata_i = d; dwe_i = w;
    @(posedge clk_i);
    model_edge(r, a, d, w);
    #1;
    reset_i = 0; daddr_i = A_COUNT; dwdata_i = 0; dwe_i = 0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, A_COUNT, 0, 4'h0);
  endtask

  task automatic test_reset;
    step(1, A_COUNT, 0, 4'h0);
    step(1, A_CTRL, 32'hFFFF, 4'hF);
    n_chk++; if (drdata_o !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h expected 0", drdata_o); end
    n_chk++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    daddr_i = A_CTRL; #1;
    n_chk++; if (drdata_o !== 32'h0) begin n_err++; $display("FAIL reset_ctrl_read: got %h expected 0", drdata_o); end
    daddr_i = A_CMP; #1;
    n_chk++; if (drdata_o !== 32'h0) begin n_err++; $display("FAIL reset_cmp_read: got %h expected 0", drdata_o); end
    daddr_i = A_COUNT; #1;
  endtask

  task automatic test_free_run;
    step(0, A_CTRL, 32'h0001, 4'hF);
    idle(9);
    n_chk++; if (drdata_o !== 32'd9) begin n_err++; $display("FAIL run_9: got %0d expected 9", drdata_o); end
    step(0, A_CTRL, 32'h0000, 4'hF);  // edge still counts, then freezes
    n_chk++; if (drdata_o !== 32'd10) begin n_err++; $display("FAIL run_10: got %0d expected 10", drdata_o); end
    idle(25);
    n_chk++; if (drdata_o !== 32'd10 || m_count !== 32'd10) begin n_err++; $display("FAIL hold_10: got %0d expected 10", drdata_o); end
  endtask

  task automatic test_prescale;
    step(0, A_CTRL, 32'h0002, 4'hF);
    n_chk++; if (drdata_o !== 32'd0) begin n_err++; $display("FAIL clr_idle: got %0d expected 0", drdata_o); end
    step(0, A_CTRL, 32'h0301, 4'hF);
    idle(40);
    n_chk++; if (drdata_o !== 32'd10) begin n_err++; $display("FAIL prescale_40: got %0d expected 10", drdata_o); end
    step(0, A_CTRL, 32'h0303, 4'hF);
    n_chk++; if (drdata_o !== 32'd0) begin n_err++; $display("FAIL clr_running: got %0d expected 0", drdata_o); end
    idle(3);
    n_chk++; if (drdata_o !== 32'd0) begin n_err++; $display("FAIL prescale_restart_3: got %0d expected 0", drdata_o); end
    idle(1);
    n_chk++; if (drdata_o !== 32'd1) begin n_err++; $display("FAIL prescale_restart_4: got %0d expected 1", drdata_o); end
  endtask

  task automatic test_compare_autoreload;
    step(0, A_CTRL, 32'h0012, 4'hF);
    step(0, A_CMP, 32'd5, 4'hF);
    step(0, A_CTRL, 32'h000D, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      idle(1);
      n_chk++; if (drdata_o !== 32'(k % 6)) begin n_err++; $display("FAIL ar_seq[%0d]: got %0d expected %0d", k, drdata_o, k % 6); end
      n_chk++; if (irq_o !== (k >= 6)) begin n_err++; $display("FAIL ar_irq[%0d]: got %b expected %b", k, irq_o, k >= 6); end
    end
    step(0, A_CTRL, 32'h001D, 4'hF);
    n_chk++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL ack_irq: got %b expected 0", irq_o); end
    n_chk++; if (drdata_o !== 32'd3) begin n_err++; $display("FAIL ack_count: got %0d expected 3", drdata_o); end
  endtask

  task automatic test_wrap_masked;
    step(0, A_CTRL, 32'h0012, 4'hF);
    step(0, A_CMP, 32'hFFFF_FFFF, 4'hF);
    step(0, A_COUNT, 32'hFFFF_FFFE, 4'hF);
    step(0, A_CTRL, 32'h0001, 4'hF);
    n_chk++; if (drdata_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_fe: got %h expected fffffffe", drdata_o); end
    idle(1);
    n_chk++; if (drdata_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_ff: got %h expected ffffffff", drdata_o); end
    idle(1);
    n_chk++; if (drdata_o !== 32'h0) begin n_err++; $display("FAIL wrap_00: got %h expected 0", drdata_o); end
    n_chk++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL wrap_irq_masked: got %b expected 0", irq_o); end
    step(0, A_CTRL, 32'h0009, 4'hF);
    n_chk++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL wrap_irq_unmask: got %b expected 1", irq_o); end
  endtask

  task automatic test_load_on_match;
    step(0, A_CTRL, 32'h0012, 4'hF);
    step(0, A_CMP, 32'd3, 4'hF);
    step(0, A_CTRL, 32'h0005, 4'hF);
    idle(3);
    step(0, A_COUNT, 32'h50, 4'hF);  // lands on the match edge
    n_chk++; if (drdata_o !== 32'h50) begin n_err++; $display("FAIL match_load: got %h expected 50", drdata_o); end
    step(0, A_CTRL, 32'h0008, 4'hF);
    n_chk++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL match_load_pending: got %b expected 1", irq_o); end
    n_chk++; if (drdata_o !== 32'h51) begin n_err++; $display("FAIL match_load_next: got %h expected 51", drdata_o); end
  endtask

  task automatic test_partial_write;
    step(0, A_CTRL, 32'h0012, 4'hF);
    step(0, A_COUNT, 32'h0000_0100, 4'hF);
    step(0, A_COUNT, 32'hDEAD_BEAB, 4'b0001);
    n_chk++; if (drdata_o !== 32'h0000_01AB) begin n_err++; $display("FAIL partial_b0: got %h expected 000001ab", drdata_o); end
    step(0, A_COUNT, 32'h7700_0000, 4'b1000);
    n_chk++; if (drdata_o !== 32'h7700_01AB) begin n_err++; $display("FAIL partial_b3: got %h expected 770001ab", drdata_o); end
    step(0, A_CTRL, 32'hFFFF_0000, 4'b1100);  // upper CTRL bytes are ignored
    idle(3);
    n_chk++; if (drdata_o !== 32'h7700_01AB) begin n_err++; $display("FAIL ctrl_upper_ignored: got %h expected 770001ab", drdata_o); end
  endtask

  task automatic test_reset_midcount;
    step(0, A_COUNT, 32'h0, 4'hF);
    step(0, A_CMP, 32'd2, 4'hF);
    step(0, A_CTRL, 32'h0009, 4'hF);
    idle(5);
    n_chk++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq: got %b expected 1", irq_o); end
    step(1, A_COUNT, 32'h1234, 4'hF);
    n_chk++; if (drdata_o !== 32'h0) begin n_err++; $display("FAIL midreset_count: got %h expected 0", drdata_o); end
    n_chk++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b expected 0", irq_o); end
    idle(4);
    n_chk++; if (drdata_o !== 32'h0) begin n_err++; $display("FAIL midreset_disabled: got %h expected 0", drdata_o); end
  endtask

  task automatic test_random;
    bit [31:0] a, d;
    bit [3:0]  w;
    bit        r;
    int        op;
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 9);
      r = ($urandom_range(0, 199) == 0);
      a = A_COUNT; d = $urandom; w = 4'h0;
      case (op)
        0, 1: begin
          a = A_CTRL; w = 4'($urandom);
          d[15:8] = 8'($urandom_range(0, 3));
          if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
        end
        2: begin a = A_COUNT; w = 4'($urandom); d = $urandom_range(0, 25); end
        3: begin a = A_CMP; w = 4'($urandom); d = $urandom_range(0, 30); end
        4: begin a = ($urandom_range(0, 1) != 0) ? 32'h0004_000C : 32'h0004_0001; w = 4'($urandom); end
        default: a = ($urandom_range(0, 3) == 0) ? A_CTRL : A_COUNT;
      endcase
      reset_i = r; daddr_i = a; dwdata_i = d; dwe_i = w;
      #1;
      n_chk++; if (drdata_o !== ((a == A_COUNT) ? m_count : 32'h0)) begin n_err++; $display("FAIL rand_rd[%0d]: got %h expected %h", n, drdata_o, (a == A_COUNT) ? m_count : 32'h0); end
      n_chk++; if (irq_o !== (m_pending && m_ie)) begin n_err++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq_o, m_pending && m_ie); end
      @(posedge clk_i);
      model_edge(r, a, d, w);
      #1;
    end
    reset_i = 0; daddr_i = A_COUNT; dwdata_i = 0; dwe_i = 0;
    #1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_compare_autoreload();
    test_wrap_masked();
    test_load_on_match();
    test_partial_write();
    test_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
